change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Consumer end of the vending core's Money_out change interface: accepts a change request
//  (amount in coin units) and drives the coin-ejector actuators with timed eject pulses.
//  Greedy denomination choice (5, 2, 1 units) with per-denomination inventory counters.
//  Sits beside Vending_Machine on the divided clock; reports busy/done/short to the core.
// PARAMETERS
//  AMT_W      3   width of change_amount / remainder (matches Money_out)
//  CNT_W      4   width of each coin inventory counter
//  INIT_CNT   8   inventory of each denomination after reset
//  PULSE_CYC  4   cycles an eject output is held high per coin
//  GAP_CYC    2   idle cycles between consecutive coins
// PORTS
//  clk            in   1      divided system clock
//  reset          in   1      asynchronous, active-low reset
//  change_valid   in   1      request strobe; accepted only when ready=1
//  change_amount  in   AMT_W  change to return, in 1-unit coins
//  refill         in   1      add refill_qty to every inventory (accepted only in IDLE)
//  refill_qty     in   CNT_W  refill quantity
//  ready          out  1      high in IDLE only
//  eject5/eject2/eject1 out 1 actuator drive, one-hot, PULSE_CYC cycles per coin
//  done           out  1      1-cycle pulse: request fully paid out
//  short_err      out  1      1-cycle pulse: request could not be completed
//  remainder      out  AMT_W  unpaid amount; held until next accepted request
//  inv5/inv2/inv1 out  CNT_W  current inventories
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, all eject/done/short_err=0, ready=1, remainder=0,
//   inventories=INIT_CNT. Reset mid-pulse drops eject outputs immediately.
//  FSM: IDLE -> SELECT -> PULSE -> GAP -> SELECT ... -> DONE|SHORT -> IDLE.
//  IDLE: change_valid&ready latches change_amount into rem (remainder=amount); -> SELECT next cycle.
//   refill in IDLE: inv += refill_qty, saturating at 2^CNT_W-1. refill outside IDLE ignored.
//   change_valid and refill together in IDLE: both taken.
//  SELECT (1 cycle): rem==0 -> DONE. Else first of 5,2,1 with value<=rem and inv>0 -> PULSE;
//   none -> SHORT.
//  PULSE: chosen eject high exactly PULSE_CYC cycles; on entry inv-- and rem-=value.
//  GAP: all ejects low GAP_CYC cycles -> SELECT. Coin period = 1+PULSE_CYC+GAP_CYC cycles.
//  DONE: done=1 one cycle, remainder=0 -> IDLE. SHORT: short_err=1 one cycle, remainder=rem -> IDLE.
//  change_valid while ready=0: ignored, no queueing. amount=0: done 2 cycles after accept, no ejects.
//  Latency accept->first eject rising edge: 2 cycles. At most one eject high at any time.
//  rem never underflows (value<=rem checked); inventories never wrap below 0.
// STRUCTURE
//  vm_defs.vh: state encodings, coin value constants (COIN5=5, COIN2=2, COIN1=1).
//  Sub-module pulse_timer: loadable down-counter, load value PULSE_CYC or GAP_CYC, expire flag.
//  Top holds FSM, rem register, three inventory counters, output registers (all registered).
// TESTING
//  amount=7, full inventories -> eject5 then eject2, done, remainder=0, inv5=7, inv2=7, inv1=8.
//  amount=0 -> no eject pulses, done 2 cycles after accept, ready back high.
//  inv5=0 (via reset INIT then drain), amount=6 -> eject2 x3, done; inv2 decremented by 3.
//  inv2=inv1=0, inv5=8, amount=3 -> no ejects, short_err pulse, remainder=3.
//  change_valid during PULSE, and refill=1 qty=15 during GAP -> both ignored; refill qty=15 in IDLE -> inv saturates at 15.
//  reset low mid-PULSE -> eject low same cycle, ready=1, inventories=8 after release.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared definitions for the change dispenser: FSM state encoding, the
//   coin selection code produced in SELECT, and the coin face values.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE,
    ST_SHORT
  } state_t;

  // Coin chosen on the SELECT -> PULSE transition; COIN_NONE otherwise.
  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_5,
    COIN_2,
    COIN_1
  } coin_t;

  localparam int COIN5 = 5;
  localparam int COIN2 = 2;
  localparam int COIN1 = 1;

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// change_dispenser_pulse_timer
//   Loadable down-counter that times the eject pulse and the inter-coin gap.
//   A load of a phase of N cycles writes N-1, so o_expire (count == 0) is
//   high in the last cycle of that phase and the FSM can leave on that edge.
// Ports
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_load     load the counter this cycle
//   i_sel_gap  0: load PULSE_CYC phase, 1: load GAP_CYC phase
//   o_expire   current phase ends at the next clock edge
module change_dispenser_pulse_timer #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_sel_gap,
  output logic o_expire
);

  localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_sel_gap ? GAP_LD : PULSE_LD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a change request as timed coin-eject pulses, choosing coins
//   greedily (5, 2, 1) subject to per-denomination inventory.
// Ports
//   clk             divided system clock
//   reset           asynchronous active-low reset
//   change_valid    request strobe, taken only while ready is high
//   change_amount   amount to return in 1-unit coins
//   refill          add refill_qty to every inventory (IDLE only)
//   refill_qty      refill quantity
//   ready           high in IDLE
//   eject5/2/1      one-hot actuator drive, PULSE_CYC cycles per coin
//   done            one-cycle pulse, request fully paid
//   short_err       one-cycle pulse, request could not be completed
//   remainder       unpaid amount, held until the next accepted request
//   inv5/inv2/inv1  current coin inventories
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W     = 3,
  parameter int CNT_W     = 4,
  parameter int INIT_CNT  = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             refill,
  input  logic [CNT_W-1:0] refill_qty,
  output logic             ready,
  output logic             eject5,
  output logic             eject2,
  output logic             eject1,
  output logic             done,
  output logic             short_err,
  output logic [AMT_W-1:0] remainder,
  output logic [CNT_W-1:0] inv5,
  output logic [CNT_W-1:0] inv2,
  output logic [CNT_W-1:0] inv1
);

  localparam logic [AMT_W-1:0] C5      = AMT_W'(COIN5);
  localparam logic [AMT_W-1:0] C2      = AMT_W'(COIN2);
  localparam logic [AMT_W-1:0] C1      = AMT_W'(COIN1);
  localparam logic [CNT_W-1:0] INV_RST = CNT_W'(INIT_CNT);

  state_t           r_state;
  state_t           w_next;
  coin_t            w_coin;
  logic             w_tload;
  logic             w_tsel_gap;
  logic             w_texpire;
  logic             w_accept;
  logic             w_refill_ok;
  logic [AMT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_inv5, r_inv2, r_inv1;
  logic             r_ready, r_done, r_short;
  logic             r_eject5, r_eject2, r_eject1;
  logic [AMT_W-1:0] r_remainder;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  change_dispenser_pulse_timer #(
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_timer (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_load    (w_tload),
    .i_sel_gap (w_tsel_gap),
    .o_expire  (w_texpire)
  );

  assign w_accept    = (r_state == ST_IDLE) && change_valid;
  assign w_refill_ok = (r_state == ST_IDLE) && refill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_coin     = COIN_NONE;
    w_tload    = 1'b0;
    w_tsel_gap = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (change_valid) w_next = ST_SELECT;
      end
      ST_SELECT: begin
        // Value <= rem is checked before choosing, so rem cannot underflow;
        // inv != 0 is checked, so inventories cannot wrap.
        if (r_rem == '0) begin
          w_next = ST_DONE;
        end else if ((r_rem >= C5) && (r_inv5 != '0)) begin
          w_coin = COIN_5;
          w_next = ST_PULSE;
        end else if ((r_rem >= C2) && (r_inv2 != '0)) begin
          w_coin = COIN_2;
          w_next = ST_PULSE;
        end else if ((r_rem >= C1) && (r_inv1 != '0)) begin
          w_coin = COIN_1;
          w_next = ST_PULSE;
        end else begin
          w_next = ST_SHORT;
        end
        if (w_next == ST_PULSE) w_tload = 1'b1;
      end
      ST_PULSE: begin
        if (w_texpire) begin
          w_next     = ST_GAP;
          w_tload    = 1'b1;
          w_tsel_gap = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_texpire) w_next = ST_SELECT;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_SHORT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem       <= '0;
      r_inv5      <= INV_RST;
      r_inv2      <= INV_RST;
      r_inv1      <= INV_RST;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_eject5    <= 1'b0;
      r_eject2    <= 1'b0;
      r_eject1    <= 1'b0;
      r_remainder <= '0;
    end else begin
      // Outputs are registered from the next state so they line up with it.
      r_ready <= (w_next == ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      r_short <= (w_next == ST_SHORT);

      // An eject is set on entry to PULSE and held while PULSE lasts.
      r_eject5 <= (w_coin == COIN_5) || (r_eject5 && (w_next == ST_PULSE));
      r_eject2 <= (w_coin == COIN_2) || (r_eject2 && (w_next == ST_PULSE));
      r_eject1 <= (w_coin == COIN_1) || (r_eject1 && (w_next == ST_PULSE));

      if (w_accept) begin
        r_rem       <= change_amount;
        r_remainder <= change_amount;
      end

      if (w_refill_ok) begin
        r_inv5 <= sat_add(r_inv5, refill_qty);
        r_inv2 <= sat_add(r_inv2, refill_qty);
        r_inv1 <= sat_add(r_inv1, refill_qty);
      end

      case (w_coin)
        COIN_5: begin
          r_inv5 <= r_inv5 - CNT_W'(1);
          r_rem  <= r_rem - C5;
        end
        COIN_2: begin
          r_inv2 <= r_inv2 - CNT_W'(1);
          r_rem  <= r_rem - C2;
        end
        COIN_1: begin
          r_inv1 <= r_inv1 - CNT_W'(1);
          r_rem  <= r_rem - C1;
        end
        default: ;
      endcase

      if (w_next == ST_DONE)  r_remainder <= '0;
      if (w_next == ST_SHORT) r_remainder <= r_rem;
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign short_err = r_short;
  assign eject5    = r_eject5;
  assign eject2    = r_eject2;
  assign eject1    = r_eject1;
  assign remainder = r_remainder;
  assign inv5      = r_inv5;
  assign inv2      = r_inv2;
  assign inv1      = r_inv1;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Directed-vector bench for change_dispenser with hand-computed results.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       change_valid = 1'b0;
  logic [2:0] change_amount = 3'd0;
  logic       refill = 1'b0;
  logic [3:0] refill_qty = 4'd0;
  logic       ready, eject5, eject2, eject1, done, short_err;
  logic [2:0] remainder;
  logic [3:0] inv5, inv2, inv1;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .refill        (refill),
    .refill_qty    (refill_qty),
    .ready         (ready),
    .eject5        (eject5),
    .eject2        (eject2),
    .eject1        (eject1),
    .done          (done),
    .short_err     (short_err),
    .remainder     (remainder),
    .inv5          (inv5),
    .inv2          (inv2),
    .inv1          (inv1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Per-request observations
  int seq, e5, e2, e1, lat, ohe, end_cyc;
  int got_done, got_short, busy_ready;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Issues one request and watches it until done/short_err. Cycle 1 is the
  // first cycle after the accepting edge. With poke set, a second request is
  // strobed in the first eject1 cycle and a refill in the first gap cycle.
  task automatic request(input logic [2:0] amt, input logic rf,
                         input logic [3:0] rq, input bit poke);
    bit   pcv, prf;
    logic p5, p2, p1;
    pcv = 1'b0; prf = 1'b0;
    p5 = 1'b0; p2 = 1'b0; p1 = 1'b0;
    seq = 0; e5 = 0; e2 = 0; e1 = 0; lat = 0; ohe = 0; end_cyc = 0;
    got_done = 0; got_short = 0;
    change_valid = 1'b1; change_amount = amt; refill = rf; refill_qty = rq;
    tick();
    change_valid = 1'b0; refill = 1'b0;
    busy_ready = 32'(ready);
    for (int c = 1; c <= 200; c++) begin
      if (32'(eject5) + 32'(eject2) + 32'(eject1) > 1) ohe++;
      e5 += 32'(eject5);
      e2 += 32'(eject2);
      e1 += 32'(eject1);
      if (eject5 && !p5) begin seq = seq * 10 + 5; if (lat == 0) lat = c; end
      if (eject2 && !p2) begin seq = seq * 10 + 2; if (lat == 0) lat = c; end
      if (eject1 && !p1) begin seq = seq * 10 + 1; if (lat == 0) lat = c; end
      change_valid = 1'b0; refill = 1'b0;
      if (poke) begin
        if (eject1 && !pcv) begin
          change_valid = 1'b1; change_amount = 3'd7; pcv = 1'b1;
        end
        if (p1 && !eject1 && !prf) begin
          refill = 1'b1; refill_qty = 4'd15; prf = 1'b1;
        end
      end
      p5 = eject5; p2 = eject2; p1 = eject1;
      if (done || short_err) begin
        got_done = 32'(done); got_short = 32'(short_err); end_cyc = c;
        break;
      end
      tick();
    end
    check("req_terminated", got_done + got_short, 1);
    change_valid = 1'b0; refill = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_ejects", 32'({eject5, eject2, eject1}), 0);
    check("rst_done", 32'(done), 0);
    check("rst_short", 32'(short_err), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_inv5", 32'(inv5), 8);
    check("rst_inv2", 32'(inv2), 8);
    check("rst_inv1", 32'(inv1), 8);
    reset = 1'b1;
    tick();

    // amount=7, full inventories: 5 then 2
    request(3'd7, 1'b0, 4'd0, 1'b0);
    check("a7_seq", seq, 52);
    check("a7_e5_cyc", e5, 4);
    check("a7_e2_cyc", e2, 4);
    check("a7_e1_cyc", e1, 0);
    check("a7_latency", lat, 2);
    check("a7_busy", busy_ready, 0);
    check("a7_onehot", ohe, 0);
    check("a7_done", got_done, 1);
    check("a7_done_cyc", end_cyc, 16);
    check("a7_remainder", 32'(remainder), 0);
    check("a7_inv5", 32'(inv5), 7);
    check("a7_inv2", 32'(inv2), 7);
    check("a7_inv1", 32'(inv1), 8);
    check("a7_ready", 32'(ready), 1);

    // amount=0: done two cycles after accept, nothing ejected
    request(3'd0, 1'b0, 4'd0, 1'b0);
    check("a0_seq", seq, 0);
    check("a0_eject_cyc", e5 + e2 + e1, 0);
    check("a0_done", got_done, 1);
    check("a0_done_cyc", end_cyc, 2);
    check("a0_ready", 32'(ready), 1);

    // Request and refill in the same IDLE cycle: both taken
    request(3'd2, 1'b1, 4'd1, 1'b0);
    check("rf_req_seq", seq, 2);
    check("rf_req_done_cyc", end_cyc, 9);
    check("rf_req_inv5", 32'(inv5), 8);
    check("rf_req_inv2", 32'(inv2), 7);
    check("rf_req_inv1", 32'(inv1), 9);

    // Drain inv5, then amount=6 pays with three 2s
    do_reset();
    for (int k = 0; k < 8; k++) request(3'd5, 1'b0, 4'd0, 1'b0);
    check("drain_inv5", 32'(inv5), 0);
    request(3'd6, 1'b0, 4'd0, 1'b0);
    check("a6_seq", seq, 222);
    check("a6_e2_cyc", e2, 12);
    check("a6_done", got_done, 1);
    check("a6_done_cyc", end_cyc, 23);
    check("a6_inv2", 32'(inv2), 5);
    check("a6_inv1", 32'(inv1), 8);
    check("a6_remainder", 32'(remainder), 0);

    // inv2=inv1=0: amount=3 is short immediately, amount=7 after one 5
    do_reset();
    for (int k = 0; k < 8; k++) request(3'd2, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 8; k++) request(3'd1, 1'b0, 4'd0, 1'b0);
    check("drain_inv2", 32'(inv2), 0);
    check("drain_inv1", 32'(inv1), 0);
    request(3'd3, 1'b0, 4'd0, 1'b0);
    check("s3_seq", seq, 0);
    check("s3_short", got_short, 1);
    check("s3_done", got_done, 0);
    check("s3_cyc", end_cyc, 2);
    check("s3_remainder", 32'(remainder), 3);
    check("s3_inv5", 32'(inv5), 8);
    request(3'd7, 1'b0, 4'd0, 1'b0);
    check("s7_seq", seq, 5);
    check("s7_short", got_short, 1);
    check("s7_cyc", end_cyc, 9);
    check("s7_remainder", 32'(remainder), 2);
    check("s7_inv5", 32'(inv5), 7);
    tick(); tick();
    check("s7_remainder_held", 32'(remainder), 2);

    // change_valid in PULSE and refill in GAP are both ignored
    do_reset();
    request(3'd1, 1'b0, 4'd0, 1'b1);
    check("pk_seq", seq, 1);
    check("pk_e1_cyc", e1, 4);
    check("pk_done_cyc", end_cyc, 9);
    check("pk_inv1", 32'(inv1), 7);
    check("pk_inv5", 32'(inv5), 8);
    check("pk_inv2", 32'(inv2), 8);
    tick(); tick(); tick();
    check("pk_no_queue_ready", 32'(ready), 1);
    check("pk_no_queue_eject", 32'({eject5, eject2, eject1}), 0);

    // Refill in IDLE: plain add, then saturation
    refill = 1'b1; refill_qty = 4'd2;
    tick();
    refill = 1'b0;
    check("rf2_inv5", 32'(inv5), 10);
    check("rf2_inv1", 32'(inv1), 9);
    refill = 1'b1; refill_qty = 4'd15;
    tick();
    refill = 1'b0;
    check("rf15_inv5", 32'(inv5), 15);
    check("rf15_inv2", 32'(inv2), 15);
    check("rf15_inv1", 32'(inv1), 15);

    // Reset asserted mid-PULSE
    change_valid = 1'b1; change_amount = 3'd5;
    tick();
    change_valid = 1'b0;
    tick();
    check("mid_eject5_on", 32'(eject5), 1);
    tick();
    check("mid_inv5", 32'(inv5), 14);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_eject5", 32'(eject5), 0);
    check("mid_rst_ready", 32'(ready), 1);
    check("mid_rst_inv5", 32'(inv5), 8);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_inv5", 32'(inv5), 8);
    check("post_rst_inv2", 32'(inv2), 8);
    check("post_rst_inv1", 32'(inv1), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
